uart_tx_arbiter: RTL
====================

# uart_tx_arbiter

Round-robin arbiter that shares one UART transmitter between four byte-producing requesters. It accepts one byte at a time over per-port valid/ready handshakes. It launches each byte into the transmitter with a one-cycle enable pulse and waits for the transmitter's completion pulse before granting the next requester. It sits between the control wrapper's byte sources and the UART transmitter, and also provides a completion watchdog and a sent-byte counter.

## Interface
- GAP_CLKS, 0: idle clocks inserted after each completion before the next arbitration (0–255).
- TIMEOUT_CLKS, 10000: maximum clocks in WAIT without tx_complete before abort (1–65535); covers a 10-bit frame at 868 clks/bit plus margin.
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  4  per-port byte-available flag; held with data stable until that port's req_ready pulse.
- req_data  in  32  packed bytes; port i at [8i+7:8i].
- req_ready  out  4  one-cycle accept pulse to the granted port; one-hot or zero.
- tx_enable  out  1  one-cycle launch pulse to the transmitter's Enable.
- tx_parallel  out  8  byte to the transmitter; held stable from launch until the next grant.
- tx_complete  in  1  one-cycle done pulse from the transmitter.
- busy  out  1  high whenever state ≠ IDLE.
- grant_id  out  2  index of the most recently granted port.
- bytes_sent  out  16  count of completed transmissions; wraps 0xFFFF→0.
- tx_error  out  1  sticky watchdog flag; cleared only by reset.

## Operation
- Reset values: req_ready=0, tx_enable=0, tx_parallel=0, busy=0, grant_id=0, bytes_sent=0, tx_error=0, state=IDLE, last-grant pointer=3, timers=0.
- States: IDLE, WAIT, GAP.
- IDLE, no req_valid set: stay in IDLE.
- IDLE, any req_valid set: select the first valid port searching from (last+1) mod 4 upward with wrap. At the edge:
  - tx_parallel ← selected byte; grant_id and last ← index.
  - req_ready[index] ← 1 and tx_enable ← 1.
  - timeout counter ← 0; state ← WAIT.
- WAIT:
  - tx_enable and req_ready return to 0 after one cycle. req_valid is ignored.
  - On tx_complete: bytes_sent += 1, then state ← GAP if GAP_CLKS > 0, else IDLE.
  - If the counter reaches TIMEOUT_CLKS−1 without tx_complete: tx_error ← 1, bytes_sent unchanged, state ← IDLE (same GAP rule).
  - If tx_complete and timeout coincide, completion wins; tx_error is not set.
- GAP: count GAP_CLKS cycles, then state ← IDLE. tx_complete is ignored.
- tx_complete in IDLE or GAP: ignored; no count change.
- Fairness: after port i is served, port i has lowest priority. With all four valid, the grant order is 0,1,2,3,0,…
- Reset asserted mid-WAIT: all outputs go to reset values immediately (asynchronous). The pending byte is considered lost; the requester's handshake already completed.

## Timing
- Arbitration latency: req_valid sampled high in IDLE at edge E0 gives req_ready and tx_enable high during cycle E0→E1, and low after E1.
- The transmitter samples Enable at E1 and loads tx_parallel at E2; tx_parallel must remain constant through at least E2. It is held until the next grant.
- Back-to-back, GAP_CLKS=0: completion seen at edge Ec → IDLE; next grant at Ec+1. The transmitter is in IDLE with tx_complete high at that point and accepts the Enable.
- Minimum grant-to-grant spacing: frame time + 2 + GAP_CLKS clocks.
- busy rises with the grant edge and falls on the edge entering IDLE.
- bytes_sent and tx_error update on the same edge that leaves WAIT.

## Test plan
- Single request: port 2 valid with 0xA5 → one req_ready=0100 pulse and one tx_enable pulse in the same cycle, tx_parallel=0xA5, grant_id=2. Transmitter model completes → bytes_sent=1, busy=0.
- Contention: all four ports valid with 0x10..0x13, held until accepted → grants 0,1,2,3, in that order. Each grant occurs only after the prior tx_complete; tx_enable occurs exactly 4 times.
- Fairness: port 0 continuously valid, port 3 raises valid during port 0's WAIT → next grant is port 3, then port 0.
- Watchdog: TIMEOUT_CLKS=50, model never completes → tx_error=1 at cycle 50 of WAIT, state IDLE, bytes_sent=0. A subsequent request is still served.
- Spurious/edge cases:
  - tx_complete pulsed in IDLE → bytes_sent unchanged.
  - tx_complete coincident with the timeout cycle → bytes_sent+1, tx_error=0.
  - GAP_CLKS=3 → next grant is 4 cycles after the completion edge.
- Reset mid-WAIT: rst_n low for 2 cycles → all outputs at reset values asynchronously. After release with port 1 valid, port 0 has priority search start and port 1 is granted.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// Byte-request and transmitter handshake bundle for uart_tx_arbiter.
//   req_valid/req_data/req_ready : four byte producers, port i on req_data[8i+7:8i]
//   tx_enable/tx_parallel        : launch pulse and byte toward the UART transmitter
//   tx_complete                  : done pulse back from the transmitter
// master = arbiter side, slave = producer/transmitter side.
interface uart_tx_arbiter_if;
   localparam int unsigned N_PORTS = 4;
   localparam int unsigned BYTE_W  = 8;

   logic [N_PORTS-1:0]        req_valid;
   logic [N_PORTS*BYTE_W-1:0] req_data;
   logic [N_PORTS-1:0]        req_ready;
   logic                      tx_enable;
   logic [BYTE_W-1:0]         tx_parallel;
   logic                      tx_complete;

   modport master (
      input  req_valid,
      input  req_data,
      input  tx_complete,
      output req_ready,
      output tx_enable,
      output tx_parallel
   );

   modport slave (
      output req_valid,
      output req_data,
      output tx_complete,
      input  req_ready,
      input  tx_enable,
      input  tx_parallel
   );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between four byte producers.
// Grants one byte at a time, launches it with a one-cycle tx_enable pulse, then
// waits for tx_complete (or a watchdog timeout) before arbitrating again.
//   clk, rst_n  : clock, asynchronous active-low reset
//   bus         : request/transmitter handshakes (uart_tx_arbiter_if.master)
//   busy        : high whenever not idle
//   grant_id    : index of the most recently granted port
//   bytes_sent  : completed transmissions, wrapping 16-bit counter
//   tx_error    : sticky watchdog flag, cleared only by reset
module uart_tx_arbiter #(
   parameter int unsigned GAP_CLKS     = 0,
   parameter int unsigned TIMEOUT_CLKS = 10000
) (
   input  logic                     clk,
   input  logic                     rst_n,
   uart_tx_arbiter_if.master        bus,
   output logic                     busy,
   output logic [1:0]               grant_id,
   output logic [15:0]              bytes_sent,
   output logic                     tx_error
);
   localparam int unsigned N_PORTS = 4;
   localparam int unsigned IDX_W   = 2;
   localparam int unsigned BYTE_W  = 8;
   localparam int unsigned CNT_W   = 16;
   localparam int unsigned GAP_W   = 8;

   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CLKS - 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CLKS > 0) ? GAP_CLKS - 1 : 0);
   localparam bit               HAS_GAP  = (GAP_CLKS > 0);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_GAP  = 2'd2
   } state_t;

   state_t             state;
   logic [IDX_W-1:0]   last_idx;
   logic [CNT_W-1:0]   tmo_cnt;
   logic [GAP_W-1:0]   gap_cnt;

   logic [IDX_W-1:0]   sel_idx_c;
   logic [BYTE_W-1:0]  sel_byte_c;
   logic               leave_c;

   // Rotating priority: nearest valid port after last_idx wins, last_idx itself is last.
   always_comb begin
      logic [IDX_W-1:0] cand;
      cand      = '0;
      sel_idx_c = last_idx;
      for (int k = N_PORTS; k >= 1; k--) begin
         cand = last_idx + IDX_W'(k);
         if (bus.req_valid[cand]) sel_idx_c = cand;
      end
   end

   assign sel_byte_c = bus.req_data[{sel_idx_c, 3'b000} +: BYTE_W];

   // Leave WAIT on completion or when the watchdog expires; completion takes precedence.
   assign leave_c = (state == ST_WAIT) && (bus.tx_complete || (tmo_cnt == TMO_LAST));

   // Arbitration FSM with registered handshake and status outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= ST_IDLE;
         last_idx        <= IDX_W'(N_PORTS - 1);
         tmo_cnt         <= '0;
         gap_cnt         <= '0;
         bus.req_ready   <= '0;
         bus.tx_enable   <= 1'b0;
         bus.tx_parallel <= '0;
         busy            <= 1'b0;
         grant_id        <= '0;
         bytes_sent      <= '0;
         tx_error        <= 1'b0;
      end else begin
         bus.req_ready <= '0;
         bus.tx_enable <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (|bus.req_valid) begin
                  bus.tx_parallel          <= sel_byte_c;
                  grant_id                 <= sel_idx_c;
                  last_idx                 <= sel_idx_c;
                  bus.req_ready[sel_idx_c] <= 1'b1;
                  bus.tx_enable            <= 1'b1;
                  tmo_cnt                  <= '0;
                  busy                     <= 1'b1;
                  state                    <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (leave_c) begin
                  if (bus.tx_complete) bytes_sent <= bytes_sent + 16'd1;
                  else                 tx_error   <= 1'b1;
                  if (HAS_GAP) begin
                     gap_cnt <= '0;
                     state   <= ST_GAP;
                  end else begin
                     busy    <= 1'b0;
                     state   <= ST_IDLE;
                  end
               end else begin
                  tmo_cnt <= tmo_cnt + CNT_W'(1);
               end
            end
            ST_GAP: begin
               if (gap_cnt == GAP_LAST) begin
                  busy  <= 1'b0;
                  state <= ST_IDLE;
               end else begin
                  gap_cnt <= gap_cnt + GAP_W'(1);
               end
            end
            default: begin
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
         endcase
      end
   end
endmodule
